// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, transaction owner and counter sizing.
package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t RESP  = 2'd2;

    typedef enum logic [1:0] {OWN_I, OWN_R, OWN_W} owner_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side signals of the arbiter; slave = arbiter, master = caches plus memory.
interface mem_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          ireq;
    logic [AW-1:0] iadr;
    logic [DW-1:0] irdata;
    logic          ival;
    logic          rreq;
    logic [AW-1:0] radr;
    logic [DW-1:0] rrdata;
    logic          rval;
    logic          wreq;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdata;
    logic          wval;
    logic          abort;
    logic          mreq;
    logic          mwe;
    logic [AW-1:0] madr;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] mrdata;
    logic          mack;

    modport slave (
        input  ireq, iadr, rreq, radr, wreq, wadr, wdata, mrdata, mack,
        output irdata, ival, rrdata, rval, wval, abort, mreq, mwe, madr, mwdata
    );

    modport master (
        output ireq, iadr, rreq, radr, wreq, wadr, wdata, mrdata, mack,
        input  irdata, ival, rrdata, rval, wval, abort, mreq, mwe, madr, mwdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational requester picker: write > read > instr, with instr forced first when starving.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   ireq,
    input  logic   rreq,
    input  logic   wreq,
    input  logic   starve,
    output owner_t owner,
    output logic   valid
);

    always_comb begin
        valid = ireq | rreq | wreq;
        owner = OWN_I;
        if (starve && ireq) begin
            owner = OWN_I;
        end else if (wreq) begin
            owner = OWN_W;
        end else if (rreq) begin
            owner = OWN_R;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache reads, dcache reads and dcache writes onto one single-port memory.
// Optional instr starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned MAXWAIT = 16
`endif
) (
    input logic      clk,
    input logic      reset,
    mem_arb_if.slave bus
);

    localparam int unsigned TCNT_W = cnt_w(TIMEOUT);

    arb_state_t    state_q, state_d;
    owner_t        owner_q;
    owner_t        pick_owner;
    logic          pick_valid;
    logic          starve;
    logic          mwe_q;
    logic          abort_q;
    logic [AW-1:0] madr_q;
    logic [DW-1:0] mwdata_q;
    logic [DW-1:0] irdata_q;
    logic [DW-1:0] rrdata_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic          tcnt_last;

    assign tcnt_last = (tcnt_q == TCNT_W'(TIMEOUT - 1));

    mem_arb_pick u_pick (
        .ireq   (bus.ireq),
        .rreq   (bus.rreq),
        .wreq   (bus.wreq),
        .starve (starve),
        .owner  (pick_owner),
        .valid  (pick_valid)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned SCNT_W = cnt_w(MAXWAIT + 1);
    logic [SCNT_W-1:0] scnt_q;

    assign starve = (scnt_q == SCNT_W'(MAXWAIT));

    // Counts grants that bypass a waiting icache request; saturates at the bound.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scnt_q <= '0;
        end else if (state_q == IDLE && pick_valid) begin
            if (pick_owner == OWN_I) begin
                scnt_q <= '0;
            end else if (bus.ireq && !starve) begin
                scnt_q <= scnt_q + 1'b1;
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   if (bus.mack || tcnt_last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            mwe_q    <= 1'b0;
            abort_q  <= 1'b0;
            madr_q   <= '0;
            mwdata_q <= '0;
            irdata_q <= '0;
            rrdata_q <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                owner_q  <= pick_owner;
                mwe_q    <= (pick_owner == OWN_W);
                abort_q  <= 1'b0;
                tcnt_q   <= '0;
                mwdata_q <= (pick_owner == OWN_W) ? bus.wdata : '0;
                unique case (pick_owner)
                    OWN_W:   madr_q <= bus.wadr;
                    OWN_R:   madr_q <= bus.radr;
                    default: madr_q <= bus.iadr;
                endcase
            end else if (state_q == ISSUE) begin
                if (bus.mack) begin
                    if (owner_q == OWN_I) irdata_q <= bus.mrdata;
                    if (owner_q == OWN_R) rrdata_q <= bus.mrdata;
                end else if (tcnt_last) begin
                    // Timed-out reads return zero data alongside the abort pulse.
                    abort_q <= 1'b1;
                    if (owner_q == OWN_I) irdata_q <= '0;
                    if (owner_q == OWN_R) rrdata_q <= '0;
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.mreq   = (state_q == ISSUE);
    assign bus.mwe    = (state_q == ISSUE) && mwe_q;
    assign bus.madr   = madr_q;
    assign bus.mwdata = mwdata_q;
    assign bus.ival   = (state_q == RESP) && (owner_q == OWN_I);
    assign bus.rval   = (state_q == RESP) && (owner_q == OWN_R);
    assign bus.wval   = (state_q == RESP) && (owner_q == OWN_W);
    assign bus.abort  = (state_q == RESP) && abort_q;
    assign bus.irdata = irdata_q;
    assign bus.rrdata = rrdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus reset,
// simultaneous-request and starvation sequences. Honours MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arb_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TO)
`ifdef MEM_ARB_STARVE_GUARD_EN
        ,
        .MAXWAIT (4)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w, r, i;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] md;
        int          lat;        // mreq cycle in which mack arrives; 0 = never
        logic        exp_mwe;
        logic [31:0] exp_mwdata;
        int          exp_cycles;
        logic [2:0]  exp_val;    // {w, r, i}
        logic        exp_abort;
        logic [31:0] exp_data;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mreq"}, bus.mreq, 0);
        chk({tag, " ival"}, bus.ival, 0);
        chk({tag, " rval"}, bus.rval, 0);
        chk({tag, " wval"}, bus.wval, 0);
        chk({tag, " abort"}, bus.abort, 0);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int n;
        string t;
        t = $sformatf("vec%0d", k);
        bus.wreq = v.w; bus.rreq = v.r; bus.ireq = v.i;
        bus.wadr = v.adr; bus.radr = v.adr; bus.iadr = v.adr; bus.wdata = v.wd;
        tick();
        chk({t, " madr"}, bus.madr, v.adr);
        chk({t, " mwe"}, bus.mwe, v.exp_mwe);
        chk({t, " mwdata"}, bus.mwdata, v.exp_mwdata);
        n = 0;
        while (bus.mreq && n < 100) begin
            n++;
            if (n == v.lat) begin
                bus.mack = 1'b1;
                bus.mrdata = v.md;
            end
            tick();
            bus.mack = 1'b0;
            bus.mrdata = 32'h0;
        end
        chk({t, " mreq cycles"}, n, v.exp_cycles);
        chk({t, " vals"}, {bus.wval, bus.rval, bus.ival}, v.exp_val);
        chk({t, " abort"}, bus.abort, v.exp_abort);
        if (v.exp_val[0]) chk({t, " irdata"}, bus.irdata, v.exp_data);
        if (v.exp_val[1]) chk({t, " rrdata"}, bus.rrdata, v.exp_data);
        bus.wreq = 1'b0; bus.rreq = 1'b0; bus.ireq = 1'b0;
        tick();
        chk_quiet({t, " after"});
    endtask

    vec_t vecs[6];

    initial begin
        bus.ireq = 0; bus.rreq = 0; bus.wreq = 0;
        bus.iadr = 0; bus.radr = 0; bus.wadr = 0; bus.wdata = 0;
        bus.mack = 0; bus.mrdata = 0;

        //          w  r  i  adr           wd            md            lat mwe mwdata        cyc val   ab data
        vecs[0] = '{0, 0, 1, 32'h40,       32'h0,        32'hDEADBEEF, 3,  0, 32'h0,        3,  3'b001, 0, 32'hDEADBEEF};
        vecs[1] = '{0, 1, 0, 32'h1000,     32'h0,        32'h12345678, 1,  0, 32'h0,        1,  3'b010, 0, 32'h12345678};
        vecs[2] = '{1, 0, 0, 32'h2004,     32'hCAFEF00D, 32'h0,        2,  1, 32'hCAFEF00D, 2,  3'b100, 0, 32'h0};
        vecs[3] = '{0, 1, 0, 32'h3000,     32'h0,        32'h0,        0,  0, 32'h0,        TO, 3'b010, 1, 32'h0};
        vecs[4] = '{0, 0, 1, 32'h44,       32'h0,        32'hA5A5_0F0F, TO, 0, 32'h0,       TO, 3'b001, 0, 32'hA5A50F0F};
        vecs[5] = '{1, 0, 0, 32'h4008,     32'h11112222, 32'h0,        0,  1, 32'h11112222, TO, 3'b100, 1, 32'h0};

        // Reset state
        tick();
        chk_quiet("reset");
        chk("reset madr", bus.madr, 0);
        chk("reset irdata", bus.irdata, 0);
        reset = 1'b1;
        tick();

        // Reset asserted mid-ISSUE, then a stale mack must be ignored
        bus.rreq = 1'b1; bus.radr = 32'h80;
        tick();
        tick();
        chk("rst mid issue mreq before", bus.mreq, 1);
        reset = 1'b0;
        tick();
        chk_quiet("rst mid issue");
        chk("rst mid issue madr", bus.madr, 0);
        bus.rreq = 1'b0;
        reset = 1'b1;
        bus.mack = 1'b1; bus.mrdata = 32'h77777777;
        tick();
        bus.mack = 1'b0; bus.mrdata = 0;
        for (int c = 0; c < 3; c++) begin
            chk_quiet($sformatf("stale mack c%0d", c));
            tick();
        end
        chk("stale mack rrdata", bus.rrdata, 0);

        for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

        // Simultaneous requests: W, R, I order with one IDLE cycle between
        begin
            logic [31:0] adr_exp[3];
            logic [2:0]  val_exp[3];
            adr_exp = '{32'h300, 32'h200, 32'h100};
            val_exp = '{3'b100, 3'b010, 3'b001};
            bus.wadr = 32'h300; bus.radr = 32'h200; bus.iadr = 32'h100;
            bus.wdata = 32'hBEEF0001;
            bus.wreq = 1; bus.rreq = 1; bus.ireq = 1;
            tick();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("prio%0d mreq", k), bus.mreq, 1);
                chk($sformatf("prio%0d madr", k), bus.madr, adr_exp[k]);
                bus.mack = 1'b1; bus.mrdata = 32'h5000 + k;
                tick();
                bus.mack = 1'b0;
                chk($sformatf("prio%0d vals", k), {bus.wval, bus.rval, bus.ival}, val_exp[k]);
                if (k == 0) bus.wreq = 0;
                if (k == 1) bus.rreq = 0;
                if (k == 2) bus.ireq = 0;
                tick();
                chk($sformatf("prio%0d idle gap", k), bus.mreq, 0);
                tick();
            end
            chk("prio done mreq", bus.mreq, 0);
            chk("prio rrdata", bus.rrdata, 32'h5001);
            chk("prio irdata", bus.irdata, 32'h5002);
        end

        // Starvation: continuous writes with a pending instr fetch
        reset = 1'b0;
        tick();
        reset = 1'b1;
        begin
            int n;
            int ig;
            ig = -1;
            bus.wadr = 32'h500; bus.iadr = 32'h600; bus.wdata = 32'h1;
            bus.wreq = 1; bus.ireq = 1;
            for (int g = 0; g < 8 && ig < 0; g++) begin
                logic want_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
                want_i = (g == 4);
`else
                want_i = 1'b0;
`endif
                n = 0;
                while (!bus.mreq && n < 5) begin
                    tick();
                    n++;
                end
                chk($sformatf("starve g%0d mreq", g), bus.mreq, 1);
                chk($sformatf("starve g%0d madr", g), bus.madr, want_i ? 32'h600 : 32'h500);
                if (!bus.mwe) ig = g;
                bus.mack = 1'b1; bus.mrdata = 32'h9000 + g;
                tick();
                bus.mack = 1'b0;
                chk($sformatf("starve g%0d vals", g), {bus.wval, bus.rval, bus.ival},
                    want_i ? 3'b001 : 3'b100);
                if (!bus.wval) bus.ireq = 0;
                tick();
            end
`ifdef MEM_ARB_STARVE_GUARD_EN
            chk("starve instr grant index", ig, 4);
`else
            chk("starve instr never granted", ig, -1);
`endif
            bus.wreq = 0; bus.ireq = 0;
            tick();
            tick();
            chk_quiet("starve end");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
